// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised sequence detector.
// Default build types below describe the SYM_W=2 / SEQ_LEN=3 configuration;
// modules derive their own widths from their parameters.
package seq_det_pkg;

  localparam int unsigned SYM_W_DEF   = 2;
  localparam int unsigned SEQ_LEN_DEF = 3;

  typedef logic [SYM_W_DEF-1:0] sym_t;
  typedef sym_t [SEQ_LEN_DEF-1:0] pattern_t;

  // Width of a counter that must hold 0..seq_len
  function automatic int unsigned prog_w(input int unsigned seq_len);
    return $clog2(seq_len + 1);
  endfunction

  // Reset value of pattern slot i: (i+1) mod 2**sym_w
  function automatic int unsigned default_sym(input int unsigned i, input int unsigned sym_w);
    return (i + 1) % (32'd1 << sym_w);
  endfunction

endpackage

// File: rtl/seq_det_prefix_match.sv
// Combinational longest-prefix search: given the registered history and the
// incoming symbol, find the longest pattern prefix that ends the stream.
module seq_det_prefix_match
  import seq_det_pkg::*;
#(
  parameter int unsigned SYM_W   = SYM_W_DEF,
  parameter int unsigned SEQ_LEN = SEQ_LEN_DEF
) (
  input  logic [SEQ_LEN-2:0][SYM_W-1:0] hist,       // hist[0] = most recent accepted symbol
  input  logic [prog_w(SEQ_LEN)-1:0]    hist_len,   // number of valid history entries
  input  logic [SYM_W-1:0]              new_sym,
  input  logic [SEQ_LEN-1:0][SYM_W-1:0] pattern,
  output logic [prog_w(SEQ_LEN)-1:0]    prefix_len, // longest proper prefix (< SEQ_LEN) matched
  output logic                          full        // whole pattern matched
);

  localparam int unsigned PW = prog_w(SEQ_LEN);

  logic [SEQ_LEN-1:0][SYM_W-1:0] win;

  // Window of the last SEQ_LEN symbols, newest at index 0
  always_comb begin
    win    = '0;
    win[0] = new_sym;
    for (int unsigned j = 1; j < SEQ_LEN; j++) win[j] = hist[j-1];
  end

  // Try every prefix length; entries beyond hist_len do not exist and never match
  always_comb begin
    logic ok;
    ok         = 1'b0;
    prefix_len = '0;
    full       = 1'b0;
    for (int unsigned k = 1; k <= SEQ_LEN; k++) begin
      ok = (k <= 32'(hist_len) + 1);
      for (int unsigned i = 0; i < k; i++) begin
        if (pattern[i] != win[k-1-i]) ok = 1'b0;
      end
      if (ok) begin
        if (k == SEQ_LEN) full = 1'b1;
        else              prefix_len = PW'(k);
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable sequence detector with longest-prefix fallback, optional
// overlap and saturating match counter.
// Optional idle timeout enabled by defining SEQ_DET_TIMEOUT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned SYM_W       = SYM_W_DEF,
  parameter int unsigned SEQ_LEN     = SEQ_LEN_DEF,
  parameter bit          OVERLAP     = 1'b0,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [SYM_W-1:0]             in_sym,
  input  logic                         cfg_we,
  input  logic [$clog2(SEQ_LEN)-1:0]   cfg_idx,
  input  logic [SYM_W-1:0]             cfg_sym,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [prog_w(SEQ_LEN)-1:0]   progress,
  output logic [CNT_W-1:0]             match_count,
  output logic                         timeout
);

  logic [SEQ_LEN-1:0][SYM_W-1:0] pattern;
  logic [SEQ_LEN-2:0][SYM_W-1:0] hist;
  logic [prog_w(SEQ_LEN)-1:0]    hist_len;
  logic [prog_w(SEQ_LEN)-1:0]    prefix_len;
  logic                          full;
  logic                          cfg_ok;
  logic                          count_inc;
  logic                          idle_expire;

  assign cfg_ok    = cfg_we && (32'(cfg_idx) < SEQ_LEN);
  assign count_inc = in_valid && !cfg_ok && full;

  seq_det_prefix_match #(
    .SYM_W   (SYM_W),
    .SEQ_LEN (SEQ_LEN)
  ) u_prefix (
    .hist       (hist),
    .hist_len   (hist_len),
    .new_sym    (in_sym),
    .pattern    (pattern),
    .prefix_len (prefix_len),
    .full       (full)
  );

`ifdef SEQ_DET_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYC+1)-1:0] idle_cnt;

  assign idle_expire = !cfg_ok && !in_valid && (progress != '0) &&
                       (32'(idle_cnt) == TIMEOUT_CYC - 1);

  // Count idle cycles while a partial match is pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (cfg_ok || in_valid || progress == '0 || idle_expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign idle_expire        = 1'b0;
`endif

  // Pattern, history and progress; config beats symbol, symbol beats timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SEQ_LEN; i++) pattern[i] <= SYM_W'(default_sym(i, SYM_W));
      hist     <= '0;
      hist_len <= '0;
      progress <= '0;
      match    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      match   <= 1'b0;
      timeout <= 1'b0;
      if (cfg_ok) begin
        pattern[cfg_idx] <= cfg_sym;
        hist             <= '0;
        hist_len         <= '0;
        progress         <= '0;
      end else if (in_valid) begin
        match <= full;
        if (full && !OVERLAP) begin
          hist     <= '0;
          hist_len <= '0;
          progress <= '0;
        end else begin
          hist[0] <= in_sym;
          for (int unsigned j = 1; j < SEQ_LEN - 1; j++) hist[j] <= hist[j-1];
          if (32'(hist_len) < SEQ_LEN - 1) hist_len <= hist_len + 1'b1;
          progress <= prefix_len;
        end
      end else if (idle_expire) begin
        hist     <= '0;
        hist_len <= '0;
        progress <= '0;
        timeout  <= 1'b1;
      end
    end
  end

  // Saturating match counter; a clear coinciding with a match leaves 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= count_inc ? CNT_W'(1) : '0;
    end else if (count_inc && match_count != '1) begin
      match_count <= match_count + 1'b1;
    end
  end

endmodule
